sha256_padder: RTL and testbench

Streaming message front end for the SHA-256 core. Accepts a big-endian 32-bit word stream with valid/ready handshake and applies FIPS 180-4 padding: the 0x80 marker, zero fill and the 64-bit bit length. Assembles 512-bit blocks and sequences the core's `init`/`next` strobes, waiting on its `ready`. Sits between the bus/DMA word source and the `sha256` core instance.

---
 rtl/sha256_padder_if.sv | 18 +
 rtl/sha256_padder.sv | 179 +++++++++++++++++
 tb/tb_sha256_padder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_padder_if.sv
// Word-stream handshake between the bus/DMA source and the SHA-256 padder.
interface sha256_padder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [1:0]  in_bytes;

  modport master (
    output in_valid, in_data, in_last, in_bytes,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes,
    output in_ready
  );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks and drives the core strobes.
// Define SHA256_PADDER_BYTE_SWAP_EN to accept little-endian host words.
//
// state | meaning
// IDLE  | no message; first word of a new message may be accepted
// FILL  | accepting message words into the block buffer
// PAD   | writing marker / zero fill / bit length, one word per cycle
// ISSUE | one-cycle core_init or core_next strobe
// WAIT  | block held while the core hashes it
// DONE  | one-cycle msg_done pulse
module sha256_padder #(
  parameter longint unsigned MAX_BLOCKS = 64'd67108864
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  sha256_padder_if.slave s_if,
  input  logic         core_ready,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  output logic         busy,
  output logic         msg_done
);

  // 512 bits per block, plus one bit of headroom for the full count
  localparam int LEN_W_RAW = $clog2(MAX_BLOCKS) + 10;
  localparam int LEN_W     = (LEN_W_RAW > 64) ? 64 : LEN_W_RAW;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PAD, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t           state, state_nxt, ret_state;
  logic [3:0]       widx;
  logic [LEN_W-1:0] len;
  logic [63:0]      len64;
  logic             first, pend80, len_ok, wait_skip;
  logic [31:0]      blk_buf [16];
  logic             accept;
  logic [31:0]      word_be, word_fmt, pad_word;
  logic [2:0]       nbytes;
  logic [5:0]       len_add;

`ifdef SHA256_PADDER_BYTE_SWAP_EN
  assign word_be = {s_if.in_data[7:0], s_if.in_data[15:8],
                    s_if.in_data[23:16], s_if.in_data[31:24]};
`else
  assign word_be = s_if.in_data;
`endif

  assign s_if.in_ready = ((state == S_IDLE) || (state == S_FILL)) && !wb_rst_i;
  assign accept        = s_if.in_valid && s_if.in_ready;
  assign len64         = 64'(len);
  assign len_add       = {nbytes, 3'b000};
  assign busy          = (state != S_IDLE);
  assign msg_done      = (state == S_DONE);

  for (genvar g = 0; g < 16; g++) begin : g_block
    assign core_block[511-32*g -: 32] = blk_buf[g];
  end

  // Unused trailing bytes are zeroed and the 0x80 marker follows the last valid byte.
  always_comb begin
    nbytes = 3'd4;
    if (s_if.in_last && (s_if.in_bytes != 2'd0))
      nbytes = {1'b0, s_if.in_bytes};
    case (nbytes)
      3'd1:    word_fmt = {word_be[31:24], 8'h80, 16'h0000};
      3'd2:    word_fmt = {word_be[31:16], 8'h80, 8'h00};
      3'd3:    word_fmt = {word_be[31:8], 8'h80};
      default: word_fmt = word_be;
    endcase
  end

  always_comb begin
    pad_word = pend80 ? 32'h8000_0000 : 32'h0000_0000;
    if (!pend80 && len_ok && (widx == 4'd14))
      pad_word = len64[63:32];
    if (!pend80 && len_ok && (widx == 4'd15))
      pad_word = len64[31:0];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_init = 1'b0;
    core_next = 1'b0;
    case (state)
      S_IDLE, S_FILL: begin
        if (accept) begin
          if (widx == 4'd15)
            state_nxt = S_ISSUE;
          else if (s_if.in_last)
            state_nxt = S_PAD;
          else
            state_nxt = S_FILL;
        end
      end
      S_PAD: begin
        if (widx == 4'd15)
          state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        core_init = first;
        core_next = !first;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!wait_skip && core_ready)
          state_nxt = ret_state;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // len_ok: the marker sits at index <= 13 of the current block, or this is the
  // trailing block after the marker filled the previous one, so words 14/15 carry the length.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      widx      <= 4'd0;
      len       <= '0;
      first     <= 1'b0;
      pend80    <= 1'b0;
      len_ok    <= 1'b0;
      wait_skip <= 1'b0;
      ret_state <= S_IDLE;
      for (int i = 0; i < 16; i++)
        blk_buf[i] <= 32'h0;
    end else begin
      case (state)
        S_IDLE, S_FILL: begin
          if (state == S_IDLE)
            first <= 1'b1;
          if (accept) begin
            blk_buf[widx] <= word_fmt;
            widx          <= widx + 4'd1;
            len           <= ((state == S_IDLE) ? '0 : len) + LEN_W'(len_add);
            if (s_if.in_last) begin
              pend80    <= (nbytes == 3'd4);
              len_ok    <= (nbytes != 3'd4) && (widx != 4'd14);
              ret_state <= S_PAD;
            end else begin
              pend80    <= 1'b0;
              len_ok    <= 1'b0;
              ret_state <= S_FILL;
            end
          end
        end
        S_PAD: begin
          blk_buf[widx] <= pad_word;
          widx          <= widx + 4'd1;
          if (pend80)
            pend80 <= 1'b0;
          if (widx == 4'd15) begin
            ret_state <= len_ok ? S_DONE : S_PAD;
            len_ok    <= 1'b1;
          end else if (pend80 && (widx <= 4'd13)) begin
            len_ok <= 1'b1;
          end
        end
        S_ISSUE: begin
          first     <= 1'b0;
          wait_skip <= 1'b1;
        end
        S_WAIT:  wait_skip <= 1'b0;
        S_DONE:  widx      <= 4'd0;
        default: widx      <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: reference FIPS padding model feeding a block scoreboard.
module tb_sha256_padder;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b1;
  logic         core_ready = 1'b1;
  logic         core_init, core_next, busy, msg_done;
  logic [511:0] core_block;

  sha256_padder_if bus ();

  sha256_padder dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .s_if       (bus.slave),
    .core_ready (core_ready),
    .core_init  (core_init),
    .core_next  (core_next),
    .core_block (core_block),
    .busy       (busy),
    .msg_done   (msg_done)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [511:0] sb_blk [$];
  bit           sb_init [$];
  int           sb_nblk [$];
  int           exp_done = 0;
  int           inits = 0;
  int           dones = 0;
  int           blocks_in_msg = 0;
  longint       cyc = 0;
  longint       strobe_cyc = 0;
  longint       acc_cyc = 0;
  int           core_lat = 1;
  bit           bp_once = 0;
  int           bp_cnt = 0;
  bit           drop_pend = 0;
  logic [511:0] held = '0;

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_bus(input logic [31:0] w);
`ifdef SHA256_PADDER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Core model: ready drops one cycle after the strobe, stays low core_lat cycles.
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      core_ready = 1'b1;
      drop_pend  = 1'b0;
      bp_cnt     = 0;
    end else begin
      if (drop_pend) begin
        core_ready = 1'b0;
        drop_pend  = 1'b0;
        if (bp_once) begin
          bp_cnt  = 100;
          bp_once = 1'b0;
        end else begin
          bp_cnt = core_lat;
        end
      end else if (!core_ready) begin
        check_val("wait_in_ready", bus.in_ready, 1'b0);
        check_val("wait_block_hold", core_block, held);
        if (bp_cnt <= 1)
          core_ready = 1'b1;
        else
          bp_cnt--;
      end
      if (core_init || core_next) begin
        check_val("one_strobe", core_init & core_next, 1'b0);
        if (core_init) begin
          check_val("init_after_done", dones, inits);
          inits++;
          blocks_in_msg = 0;
          strobe_cyc = cyc;
        end
        blocks_in_msg++;
        check_val("sb_pending", sb_blk.size() > 0, 1'b1);
        if (sb_blk.size() > 0) begin
          check_val("block", core_block, sb_blk.pop_front());
          check_val("strobe_kind", core_init, sb_init.pop_front());
        end
        held = core_block;
        drop_pend = 1'b1;
      end
      if (msg_done) begin
        dones++;
        check_val("blocks_per_msg", blocks_in_msg, (sb_nblk.size() > 0) ? sb_nblk.pop_front() : -1);
      end
    end
  end

  task automatic push_expect(input logic [7:0] b [$]);
    logic [7:0]      q [$];
    longint unsigned bl;
    logic [511:0]    blk;
    int              nb;
    q  = b;
    bl = longint'(q.size()) * 8;
    q.push_back(8'h80);
    while ((q.size() % 64) != 56) q.push_back(8'h00);
    for (int i = 7; i >= 0; i--) q.push_back(bl[8*i +: 8]);
    nb = q.size() / 64;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = q[64*k+j];
      sb_blk.push_back(blk);
      sb_init.push_back(k == 0);
    end
    sb_nblk.push_back(nb);
  endtask

  task automatic send_word(input logic [31:0] w, input bit last, input logic [1:0] nb);
    bit acc = 1'b0;
    int budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = to_bus(w);
    bus.in_last  = last;
    bus.in_bytes = nb;
    while (!acc && budget < 400) begin
      @(negedge wb_clk_i);
      acc = bus.in_ready;
      @(posedge wb_clk_i);
      #1;
      budget++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_val("word_accept", acc, 1'b1);
    if (last) acc_cyc = cyc;
  endtask

  // Unused bytes of the last word carry garbage that the padder must clear.
  task automatic send_msg(input int nbytes, input bit model);
    logic [7:0]  b [$];
    logic [31:0] w;
    int          nw;
    int          idx;
    for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom_range(0, 255)));
    if (model) begin
      push_expect(b);
      exp_done++;
    end
    nw = (nbytes + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 4; j++) begin
        idx = 4*k + j;
        w[31-8*j -: 8] = (idx < nbytes) ? b[idx] : 8'($urandom_range(0, 255));
      end
      send_word(w, k == nw - 1, 2'(nbytes % 4));
    end
  endtask

  task automatic send_abc();
    sb_blk.push_back({32'h61626380, 448'h0, 32'h00000018});
    sb_init.push_back(1'b1);
    sb_nblk.push_back(1);
    exp_done++;
    send_word(32'h61626300, 1'b1, 2'd3);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((dones != exp_done || busy) && n < 3000) begin
      @(posedge wb_clk_i);
      #1;
      n++;
    end
    check_val("msg_complete", dones, exp_done);
    check_val("idle_after_msg", busy, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_init"}, core_init, 1'b0);
    check_val({tag, "_next"}, core_next, 1'b0);
    check_val({tag, "_done"}, msg_done, 1'b0);
    check_val({tag, "_block"}, core_block, 512'h0);
  endtask

  initial begin
    int lens [12] = '{56, 64, 55, 60, 61, 63, 65, 1, 2, 4, 119, 120};
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    bus.in_last  = 1'b0;
    bus.in_bytes = 2'd0;

    repeat (3) @(posedge wb_clk_i);
    #1;
    check_quiet("reset");
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    check_val("in_ready_after_rst", bus.in_ready, 1'b1);

    send_abc();
    wait_idle();
    check_val("abc_pad_latency", strobe_cyc - acc_cyc, 15);

    foreach (lens[i]) begin
      core_lat = $urandom_range(0, 3);
      send_msg(lens[i], 1'b1);
      wait_idle();
    end
    for (int i = 0; i < 4; i++) begin
      core_lat = $urandom_range(0, 3);
      send_msg($urandom_range(1, 150), 1'b1);
      wait_idle();
    end

    // Long core stall; second message queues behind the first.
    core_lat = 1;
    bp_once  = 1'b1;
    send_abc();
    send_msg(20, 1'b1);
    wait_idle();

    // Abort a message while padding.
    send_msg(8, 1'b0);
    repeat (3) @(posedge wb_clk_i);
    #3;
    check_val("pad_busy", busy, 1'b1);
    wb_rst_i = 1'b1;
    #1;
    check_quiet("abort");
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    check_val("in_ready_after_abort", bus.in_ready, 1'b1);
    send_abc();
    wait_idle();
    check_val("abc2_pad_latency", strobe_cyc - acc_cyc, 15);

    check_val("sb_drained", sb_blk.size(), 0);
    check_val("done_total", dones, exp_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
